// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the program counter, assembles one
// INST_WIDTH instruction from NB little-endian byte reads of a byte-wide
// instruction memory, and hands it to decode with a one-cycle ready pulse.
// A PC redirect (pc_load) overrides the PC and aborts any fetch in flight.
module fetch_unit #(
  parameter int M_WIDTH    = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int INST_WIDTH = 32,   // integer multiple of M_WIDTH
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [M_WIDTH-1:0]    mem_data,
  input  logic                  mem_ready,
  output logic [INST_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  ready,
  output logic                  busy
);

  // Bytes per instruction and the width of the byte counter.
  localparam int NB = INST_WIDTH / M_WIDTH;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(NB - 1);
  localparam logic [ADDR_WIDTH-1:0] INST_BYTES = ADDR_WIDTH'(NB);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   pc_reg, pc_next;
  logic [ADDR_WIDTH-1:0]   base_reg, base_next;
  logic [CW-1:0]           count_reg, count_next;
  logic [INST_WIDTH-1:0]   inst_reg, inst_next;
  logic [ADDR_WIDTH-1:0]   inst_pc_reg, inst_pc_next;
  logic [ADDR_WIDTH-1:0]   mem_addr_reg, mem_addr_next;
  logic                    mem_rd_reg, mem_rd_next;
  logic                    ready_reg, ready_next;

  // A byte is consumed only while actively reading; a redirect in the same
  // cycle wins and the returned byte is dropped.
  logic take_byte;
  assign take_byte = (state_reg == READ) && mem_rd_reg && mem_ready && !pc_load;

  // Full instruction as it would look if the incoming byte were the last:
  // the top lane comes straight from memory, lower lanes from the buffer.
  logic [INST_WIDTH-1:0] assembled;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      if (gi == NB - 1) begin : g_top
        assign assembled[gi*M_WIDTH +: M_WIDTH] = mem_data;
      end else begin : g_buf
        logic [M_WIDTH-1:0] lane_reg;

        // Capture the byte belonging to this lane when it is returned.
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            lane_reg <= '0;
          end else if (take_byte && (count_reg == CW'(gi))) begin
            lane_reg <= mem_data;
          end
        end

        assign assembled[gi*M_WIDTH +: M_WIDTH] = lane_reg;
      end
    end
  endgenerate

  // State and output registers; reset returns everything to zero/RESET_PC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      pc_reg       <= RESET_PC;
      base_reg     <= '0;
      count_reg    <= '0;
      inst_reg     <= '0;
      inst_pc_reg  <= '0;
      mem_addr_reg <= '0;
      mem_rd_reg   <= 1'b0;
      ready_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      base_reg     <= base_next;
      count_reg    <= count_next;
      inst_reg     <= inst_next;
      inst_pc_reg  <= inst_pc_next;
      mem_addr_reg <= mem_addr_next;
      mem_rd_reg   <= mem_rd_next;
      ready_reg    <= ready_next;
    end
  end

  // Next-state and next-output logic; everything holds unless changed,
  // except ready which is a single-cycle pulse.
  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    base_next     = base_reg;
    count_next    = count_reg;
    inst_next     = inst_reg;
    inst_pc_next  = inst_pc_reg;
    mem_addr_next = mem_addr_reg;
    mem_rd_next   = mem_rd_reg;
    ready_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (pc_load) begin
          // Redirect takes priority; a simultaneous en is dropped.
          pc_next = pc_in;
        end else if (en) begin
          base_next     = pc_reg;
          count_next    = '0;
          mem_addr_next = pc_reg;
          mem_rd_next   = 1'b1;
          state_next    = READ;
        end
      end

      READ: begin
        if (pc_load) begin
          // Abort: the partially assembled instruction is never published.
          pc_next     = pc_in;
          mem_rd_next = 1'b0;
          state_next  = IDLE;
        end else if (take_byte) begin
          if (count_reg == LAST_BYTE) begin
            inst_next    = assembled;
            inst_pc_next = base_reg;
            pc_next      = base_reg + INST_BYTES;
            count_next   = '0;
            mem_rd_next  = 1'b0;
            ready_next   = 1'b1;
            state_next   = DONE;
          end else begin
            count_next    = count_reg + CW'(1);
            // Address wraps naturally at 2^ADDR_WIDTH.
            mem_addr_next = base_reg + ADDR_WIDTH'(count_reg) + ADDR_WIDTH'(1);
          end
        end
      end

      DONE: begin
        // Ready has had its one cycle; en here is ignored.
        if (pc_load) begin
          pc_next = pc_in;
        end
        mem_rd_next = 1'b0;
        state_next  = IDLE;
      end

      default: begin
        mem_rd_next = 1'b0;
        state_next  = IDLE;
      end
    endcase
  end

  assign mem_addr = mem_addr_reg;
  assign mem_rd   = mem_rd_reg;
  assign inst     = inst_reg;
  assign inst_pc  = inst_pc_reg;
  assign ready    = ready_reg;
  assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a byte memory model with optional
// stalls, and a scoreboard of expected addresses and instructions pushed
// when a fetch is requested and popped as the DUT produces them.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        pc_load = 1'b0;
  logic [15:0] pc_in = 16'h0000;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data = 8'h00;
  logic        mem_ready = 1'b0;
  logic [31:0] inst;
  logic [15:0] inst_pc;
  logic        ready;
  logic        busy;

  logic [7:0]  mem [65536];
  logic [15:0] addr_q [$];
  logic [47:0] exp_q [$];   // {inst_pc, inst}
  int          stall_left = 0;
  logic [15:0] stall_addr = 16'h0000;
  int          n_cmp = 0;
  int          n_bad = 0;

  fetch_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .pc_load   (pc_load),
    .pc_in     (pc_in),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .inst      (inst),
    .inst_pc   (inst_pc),
    .ready     (ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Advance to the next falling edge and present memory response for the
  // following rising edge.
  task automatic tick();
    @(negedge clk);
    mem_data = mem[mem_addr];
    if (mem_rd === 1'b1 && stall_left > 0 && mem_addr == stall_addr) begin
      mem_ready = 1'b0;
      stall_left--;
    end else begin
      mem_ready = 1'b1;
    end
  endtask

  task automatic load_pc(input logic [15:0] v);
    pc_load = 1'b1;
    pc_in   = v;
    tick();
    pc_load = 1'b0;
  endtask

  // One complete fetch from base, optionally stalling s_cyc cycles at s_addr
  // and optionally pulsing en while busy.
  task automatic run_fetch(input logic [15:0] base, input logic [15:0] s_addr,
                           input int s_cyc, input bit poke_en);
    logic [31:0] exp_inst;
    logic [31:0] old_inst;
    logic [47:0] e;
    logic [15:0] a;
    int k;
    bit got;
    for (int i = 0; i < 4; i++) begin
      a = base + 16'(i);
      addr_q.push_back(a);
      exp_inst[i*8 +: 8] = mem[a];
    end
    exp_q.push_back({base, exp_inst});
    stall_addr = s_addr;
    stall_left = s_cyc;
    old_inst = inst;
    en = 1'b1;
    k = -1;
    got = 1'b0;
    while (!got && k < 40) begin
      tick();
      k++;
      if (k == 0) en = 1'b0;
      if (poke_en && k == 2) en = 1'b1;
      if (poke_en && k == 3) en = 1'b0;
      if (mem_rd === 1'b1) begin
        n_cmp++;
        if (addr_q.size() == 0) begin
          n_bad++;
          $display("FAIL extra_read: got addr %h required no read", mem_addr);
        end else begin
          if (mem_addr !== addr_q[0]) begin
            n_bad++;
            $display("FAIL mem_addr: got %h required %h (k=%0d)", mem_addr, addr_q[0], k);
          end
          if (mem_ready) void'(addr_q.pop_front());
        end
      end
      if (ready === 1'b1) begin
        got = 1'b1;
        e = exp_q.pop_front();
        n_cmp++;
        if (inst !== e[31:0]) begin
          n_bad++;
          $display("FAIL inst: got %h required %h", inst, e[31:0]);
        end
        n_cmp++;
        if (inst_pc !== e[47:32]) begin
          n_bad++;
          $display("FAIL inst_pc: got %h required %h", inst_pc, e[47:32]);
        end
        n_cmp++;
        if (k != 4 + s_cyc) begin
          n_bad++;
          $display("FAIL latency: got %0d required %0d", k, 4 + s_cyc);
        end
      end else if (inst !== old_inst) begin
        n_cmp++;
        n_bad++;
        $display("FAIL inst_early: got %h required %h", inst, old_inst);
      end
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: got no ready required ready at base %h", base);
    end
    n_cmp++;
    if (addr_q.size() != 0) begin
      n_bad++;
      $display("FAIL reads_missing: got %0d left required 0", addr_q.size());
    end
    addr_q.delete();
    exp_q.delete();
    en = 1'b0;
    tick();
    n_cmp++;
    if (ready !== 1'b0 || busy !== 1'b0 || mem_rd !== 1'b0) begin
      n_bad++;
      $display("FAIL after_ready: got ready=%b busy=%b mem_rd=%b required 0/0/0",
               ready, busy, mem_rd);
    end
    $display("fetch base=%h inst=%h inst_pc=%h latency=%0d", base, inst, inst_pc, k);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({mem_addr, mem_rd, inst, inst_pc, ready, busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got addr=%h rd=%b inst=%h pc=%h rdy=%b busy=%b required all 0",
               mem_addr, mem_rd, inst, inst_pc, ready, busy);
    end
    $display("reset outputs addr=%h rd=%b inst=%h", mem_addr, mem_rd, inst);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    run_fetch(16'h0000, 16'h0000, 0, 1'b0);
    n_cmp++;
    if (inst !== 32'h00A00513) begin
      n_bad++;
      $display("FAIL basic_inst: got %h required 00a00513", inst);
    end
  endtask

  task automatic test_stall();
    load_pc(16'h0000);
    run_fetch(16'h0000, 16'h0001, 2, 1'b1);
    n_cmp++;
    if (inst !== 32'h00A00513) begin
      n_bad++;
      $display("FAIL stall_inst: got %h required 00a00513", inst);
    end
  endtask

  task automatic test_back_to_back();
    load_pc(16'h0000);
    run_fetch(16'h0000, 16'h0000, 0, 1'b0);
    run_fetch(16'h0004, 16'h0000, 0, 1'b0);
    run_fetch(16'h0008, 16'h0000, 0, 1'b0);
  endtask

  task automatic test_abort();
    logic [31:0] old_inst;
    int k;
    old_inst = inst;
    en = 1'b1;
    tick();
    en = 1'b0;
    k = 0;
    while (!(mem_rd === 1'b1 && mem_addr == 16'h000E) && k < 10) begin
      tick();
      k++;
    end
    n_cmp++;
    if (mem_addr !== 16'h000E) begin
      n_bad++;
      $display("FAIL abort_reach: got addr %h required 000e", mem_addr);
    end
    pc_load = 1'b1;
    pc_in   = 16'h0100;
    tick();
    pc_load = 1'b0;
    n_cmp++;
    if (mem_rd !== 1'b0 || busy !== 1'b0 || ready !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_state: got rd=%b busy=%b ready=%b required 0/0/0",
               mem_rd, busy, ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (ready !== 1'b0 || inst !== old_inst) begin
        n_bad++;
        $display("FAIL abort_quiet: got ready=%b inst=%h required 0 / %h",
                 ready, inst, old_inst);
      end
    end
    $display("abort inst=%h mem_rd=%b", inst, mem_rd);
    run_fetch(16'h0100, 16'h0000, 0, 1'b0);
  endtask

  task automatic test_wrap();
    pc_load = 1'b1;
    pc_in   = 16'hFFFE;
    en      = 1'b1;
    tick();
    pc_load = 1'b0;
    en      = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || mem_rd !== 1'b0) begin
      n_bad++;
      $display("FAIL load_en: got busy=%b rd=%b required 0/0", busy, mem_rd);
    end
    run_fetch(16'hFFFE, 16'h0000, 0, 1'b0);
    run_fetch(16'h0002, 16'h0000, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    en = 1'b1;
    tick();
    en = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    n_cmp++;
    if ({mem_addr, mem_rd, inst, inst_pc, ready, busy} !== '0) begin
      n_bad++;
      $display("FAIL midreset_outputs: got addr=%h rd=%b inst=%h pc=%h rdy=%b busy=%b required all 0",
               mem_addr, mem_rd, inst, inst_pc, ready, busy);
    end
    $display("mid-fetch reset addr=%h busy=%b", mem_addr, busy);
    rst_n = 1'b1;
    run_fetch(16'h0000, 16'h0000, 0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);
    mem[0] = 8'h13;
    mem[1] = 8'h05;
    mem[2] = 8'hA0;
    mem[3] = 8'h00;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_abort();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage; sits directly upstream of the decode stage.
- Reads one INST_WIDTH-bit instruction from byte-wide (M_WIDTH) instruction memory, one byte per memory handshake, little-endian.
- Presents the assembled instruction with its address and a one-cycle ready pulse; this pulse drives the decode stage's en.
- Owns the program counter; a redirect input overrides it for jumps and branches.

Parameters:
- M_WIDTH, 8, memory data width in bits.
- ADDR_WIDTH, 16, PC and memory address width.
- INST_WIDTH, 32, instruction width; must be an integer multiple of M_WIDTH.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  request one instruction fetch.
- pc_load  in  1  redirect the PC (jump/branch).
- pc_in  in  ADDR_WIDTH  redirect target.
- mem_addr  out  ADDR_WIDTH  byte address to memory.
- mem_rd  out  1  memory read request.
- mem_data  in  M_WIDTH  memory read data; valid when mem_ready=1.
- mem_ready  in  1  memory completes the current read.
- inst  out  INST_WIDTH  last completed instruction, drives decode inst.
- inst_pc  out  ADDR_WIDTH  address of inst.
- ready  out  1  one-cycle pulse: inst/inst_pc are newly valid.
- busy  out  1  fetch in progress (state != IDLE).

Behaviour:
- Reset (rst_n=0 at a clock edge) applies regardless of state, including mid-fetch:
  - state=IDLE, pc=RESET_PC, byte count=0, assembly buffer=0.
  - inst=0, inst_pc=0, mem_addr=0, mem_rd=0, ready=0, busy=0.
- NB = INST_WIDTH/M_WIDTH bytes per instruction (4 at defaults).
- States: IDLE, READ, DONE. All outputs are registered.
- IDLE:
  - If pc_load=1: pc<=pc_in; en is ignored that cycle.
  - Else if en=1: latch base=pc, count=0, mem_addr<=pc, mem_rd<=1, go to READ.
- READ:
  - mem_rd held at 1 and mem_addr held stable until mem_ready=1 is sampled.
  - On mem_ready=1: buffer byte[count]<=mem_data and count increments.
  - If more bytes remain: mem_addr<=base+count+1, stay in READ.
  - If this was byte NB-1:
    - inst<={mem_data, buffer bytes NB-2..0}, inst_pc<=base, pc<=base+NB.
    - mem_rd<=0, ready<=1, go to DONE.
- DONE: ready is high for exactly this one cycle; ready<=0, go to IDLE. en sampled in DONE is ignored.
- Latency: with a zero-wait memory (mem_ready=1 whenever mem_rd=1), en sampled at edge E gives mem_rd high after E and ready high after edge E+NB. Each memory wait cycle adds one cycle.
- pc_load while busy (READ or DONE):
  - Abort: pc<=pc_in, mem_rd<=0, ready<=0, go to IDLE.
  - inst/inst_pc keep their previous values; a byte returned in the same cycle is discarded.
- en while busy is ignored; no queuing.
- inst and inst_pc change only on fetch completion. Partial assembly is never visible on inst.
- Address arithmetic is modulo 2^ADDR_WIDTH. A fetch starting at 2^ADDR_WIDTH-2 reads bytes at FFFE, FFFF, 0000, 0001 (16-bit), and pc wraps likewise.
- mem_ready while mem_rd=0 is ignored.

Test Plan:
- Zero-wait memory holding bytes 13,05,A0,00 at 0..3; reset, then pulse en -> mem_addr 0,1,2,3 on consecutive cycles; ready pulses once 4 cycles after en; inst=0x00A00513, inst_pc=0, busy drops on the cycle after ready.
- Same fetch with mem_ready low for 2 cycles on byte 1 -> mem_addr stays 1 with mem_rd=1 during the stall; ready arrives 2 cycles later; inst unchanged from the zero-wait case.
- Two back-to-back fetches (en in the cycle after ready) -> second fetch reads addresses 4..7, inst_pc=4, pc=8 afterwards.
- pc_load=1 with pc_in=0x0100 during byte 2 of a fetch -> mem_rd drops next cycle, no ready pulse, inst unchanged; next en fetches from 0x0100.
- pc_load=1 (pc_in=0xFFFE) and en=1 in the same IDLE cycle -> no fetch starts; following en reads FFFE, FFFF, 0000, 0001; pc=0x0002 after completion.
- rst_n=0 mid-fetch -> next cycle all outputs 0 and busy=0; en afterwards fetches from RESET_PC.
